// File: rtl/conv_mem_responder.sv
// Memory-side responder for the convolution engine: image RAM, L0/L1 layer banks,
// host load stream, engine start handshake and L1 result drain stream.
module conv_mem_responder #(
    parameter int unsigned DW     = 20,
    parameter int unsigned IMG_AW = 12,
    parameter int unsigned L1_AW  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DW-1:0]     load_data,
    output logic              load_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [IMG_AW-1:0] iaddr,
    output logic [DW-1:0]     idata,
    input  logic              cwr,
    input  logic [IMG_AW-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [IMG_AW-1:0] caddr_rd,
    output logic [DW-1:0]     cdata_rd,
    input  logic [2:0]        csel,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DW-1:0]     dump_data,
    output logic [L1_AW-1:0]  dump_addr,
    output logic              done,
    output logic              err_sel
);

    localparam int unsigned IMG_N = 1 << IMG_AW;
    localparam int unsigned L1_N  = 1 << L1_AW;

    typedef enum logic [2:0] {
        S_LOAD,
        S_ARM,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t              state;
    logic [IMG_AW-1:0]   ld_cnt;
    logic [DW-1:0]       img [IMG_N];
    logic [DW-1:0]       l0  [IMG_N];
    logic [DW-1:0]       l1  [L1_N];
    logic                sel_l0;
    logic                sel_l1;
    logic                sel_bad;

    assign sel_l0  = (csel == 3'b001);
    assign sel_l1  = (csel == 3'b011);
    assign sel_bad = !sel_l0 && !sel_l1;

    // Arrays are never reset; layer accesses are serviced in every state.
    always_ff @(posedge clk) begin
        if (!reset && state == S_LOAD && load_valid) begin
            img[ld_cnt] <= load_data;
        end
        if (cwr && sel_l0) begin
            l0[caddr_wr] <= cdata_wr;
        end
        if (cwr && sel_l1) begin
            l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        end
    end

    assign idata     = img[iaddr];
    assign dump_data = l1[dump_addr];

    // Reads see the array before any same-edge write lands.
    always_comb begin
        cdata_rd = '0;
        if (crd && sel_l0) begin
            cdata_rd = l0[caddr_rd];
        end else if (crd && sel_l1) begin
            cdata_rd = l1[caddr_rd[L1_AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sel <= 1'b0;
        end else if ((cwr || crd) && sel_bad) begin
            err_sel <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LOAD;
            ld_cnt     <= '0;
            load_ready <= 1'b1;
            ready      <= 1'b0;
            dump_valid <= 1'b0;
            dump_addr  <= '0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_valid) begin
                        ld_cnt <= ld_cnt + IMG_AW'(1);
                        if (ld_cnt == IMG_AW'(IMG_N - 1)) begin
                            state      <= S_ARM;
                            load_ready <= 1'b0;
                            ready      <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (busy) begin
                        state <= S_RUN;
                        ready <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!busy) begin
                        state      <= S_DUMP;
                        dump_valid <= 1'b1;
                        dump_addr  <= '0;
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (dump_addr == L1_AW'(L1_N - 1)) begin
                            state      <= S_DONE;
                            dump_valid <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            dump_addr <= dump_addr + L1_AW'(1);
                        end
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_responder.sv
// Randomized self-checking bench for conv_mem_responder against array-based memory models.
module tb_conv_mem_responder;

    localparam int unsigned DW     = 20;
    localparam int unsigned IMG_AW = 12;
    localparam int unsigned L1_AW  = 10;
    localparam int unsigned IMG_N  = 4096;
    localparam int unsigned L1_N   = 1024;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_valid = 1'b0;
    logic [DW-1:0]     load_data = '0;
    logic              load_ready;
    logic              ready;
    logic              busy = 1'b0;
    logic [IMG_AW-1:0] iaddr = '0;
    logic [DW-1:0]     idata;
    logic              cwr = 1'b0;
    logic [IMG_AW-1:0] caddr_wr = '0;
    logic [DW-1:0]     cdata_wr = '0;
    logic              crd = 1'b0;
    logic [IMG_AW-1:0] caddr_rd = '0;
    logic [DW-1:0]     cdata_rd;
    logic [2:0]        csel = 3'b000;
    logic              dump_valid;
    logic              dump_ready = 1'b0;
    logic [DW-1:0]     dump_data;
    logic [L1_AW-1:0]  dump_addr;
    logic              done;
    logic              err_sel;

    conv_mem_responder #(.DW(DW), .IMG_AW(IMG_AW), .L1_AW(L1_AW)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_addr(dump_addr), .done(done), .err_sel(err_sel)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] m_img [IMG_N];
    logic [DW-1:0] m_l0  [IMG_N];
    logic [DW-1:0] m_l1  [L1_N];
    bit m_err = 1'b0;

    function automatic bit bad_sel(input logic [2:0] sel);
        return (sel != 3'b001) && (sel != 3'b011);
    endfunction

    function automatic logic [DW-1:0] ref_read(input bit rd, input logic [2:0] sel, input logic [11:0] a);
        if (!rd) return '0;
        if (sel == 3'b001) return m_l0[a];
        if (sel == 3'b011) return m_l1[a % 1024];
        return '0;
    endfunction

    function automatic void ref_write(input bit wr, input logic [2:0] sel, input logic [11:0] a,
                                      input logic [DW-1:0] d);
        if (!wr) return;
        if (sel == 3'b001) m_l0[a] = d;
        else if (sel == 3'b011) m_l1[a % 1024] = d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit wr, input logic [2:0] sel, input logic [11:0] wa,
                          input logic [DW-1:0] wd, input bit rd, input logic [11:0] ra,
                          output logic [DW-1:0] obs);
        cwr = wr; csel = sel; caddr_wr = wa; cdata_wr = wd; crd = rd; caddr_rd = ra;
        #1;
        obs = cdata_rd;
        tick();
        cwr = 1'b0; crd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load_valid = 1'b0; busy = 1'b0; dump_ready = 1'b0; cwr = 1'b0; crd = 1'b0;
        tick();
        m_err = 1'b0;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid got %b want 0", dump_valid); end
        checks++; if (dump_addr !== '0) begin errors++; $display("FAIL reset_dump_addr got %0d want 0", dump_addr); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL reset_err_sel got %b want 0", err_sel); end
        reset = 1'b0;
    endtask

    task automatic test_load(input int n, input bit full);
        int acc = 0;
        int cyc = 0;
        while (acc < n && cyc < 20000) begin
            load_valid = ($urandom_range(3) != 0);
            load_data  = DW'($urandom);
            #1;
            checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1 at word %0d", load_ready, acc); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL load_early_ready got %b want 0 at word %0d", ready, acc); end
            if (load_valid) begin
                m_img[acc] = load_data;
                acc++;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        if (acc < n) begin errors++; checks++; $display("FAIL load_timeout got %0d words want %0d", acc, n); end
        if (full) begin
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL load_ready_rise got %b want 1", ready); end
            checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_fall got %b want 0", load_ready); end
        end
    endtask

    task automatic test_idata(input int n);
        for (int i = 0; i < n; i++) begin
            iaddr = (i == 0) ? 12'd0 : (i == 1) ? 12'd64 : (i == 2) ? 12'd4095 : (i == 3) ? 12'd50 : IMG_AW'($urandom);
            #1;
            checks++; if (idata !== m_img[iaddr]) begin errors++; $display("FAIL idata addr %0d got %h want %h", iaddr, idata, m_img[iaddr]); end
            tick();
        end
    endtask

    task automatic test_arm();
        for (int i = 0; i < 10; i++) begin
            busy = 1'b0; load_valid = 1'b1; load_data = 20'hABCDE;
            #1;
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready cycle %0d got %b want 1", i, ready); end
            tick();
        end
        load_valid = 1'b0; busy = 1'b1;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL arm_ready_drop got %b want 0", ready); end
    endtask

    task automatic test_fill();
        logic [DW-1:0] obs;
        logic [DW-1:0] d;
        logic [11:0] a;
        for (int i = 0; i < int'(IMG_N); i++) begin
            d = DW'($urandom); a = 12'(i);
            access(1'b1, 3'b001, a, d, 1'b0, 12'd0, obs);
            ref_write(1'b1, 3'b001, a, d);
        end
        for (int i = 0; i < int'(L1_N); i++) begin
            d = DW'($urandom); a = {2'($urandom), 10'(i)};
            access(1'b1, 3'b011, a, d, 1'b0, 12'd0, obs);
            ref_write(1'b1, 3'b011, a, d);
        end
        checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL fill_err_sel got %b want 0", err_sel); end
    endtask

    task automatic test_layer_directed();
        logic [DW-1:0] obs;
        access(1'b1, 3'b001, 12'h123, 20'h0ABCD, 1'b0, 12'h000, obs);
        ref_write(1'b1, 3'b001, 12'h123, 20'h0ABCD);
        access(1'b0, 3'b001, 12'h000, 20'h00000, 1'b1, 12'h123, obs);
        checks++; if (obs !== 20'h0ABCD) begin errors++; $display("FAIL l0_readback got %h want 0abcd", obs); end
        access(1'b1, 3'b001, 12'h123, 20'h11111, 1'b1, 12'h123, obs);
        ref_write(1'b1, 3'b001, 12'h123, 20'h11111);
        checks++; if (obs !== 20'h0ABCD) begin errors++; $display("FAIL same_cycle_old got %h want 0abcd", obs); end
        access(1'b0, 3'b001, 12'h000, 20'h00000, 1'b1, 12'h123, obs);
        checks++; if (obs !== 20'h11111) begin errors++; $display("FAIL same_cycle_new got %h want 11111", obs); end
        access(1'b1, 3'b011, 12'h7FF, 20'h12345, 1'b0, 12'h000, obs);
        ref_write(1'b1, 3'b011, 12'h7FF, 20'h12345);
        checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL err_sel_clean got %b want 0", err_sel); end
        access(1'b1, 3'b010, 12'h7FF, 20'h55555, 1'b0, 12'h000, obs);
        m_err = 1'b1;
        checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL err_sel_set got %b want 1", err_sel); end
        access(1'b0, 3'b011, 12'h000, 20'h00000, 1'b1, 12'h3FF, obs);
        checks++; if (obs !== 20'h12345) begin errors++; $display("FAIL l1_readback got %h want 12345", obs); end
        access(1'b0, 3'b001, 12'h000, 20'h00000, 1'b1, 12'h7FF, obs);
        checks++; if (obs !== m_l0[12'h7FF]) begin errors++; $display("FAIL dropped_write_l0 got %h want %h", obs, m_l0[12'h7FF]); end
        access(1'b0, 3'b001, 12'h000, 20'h00000, 1'b0, 12'h123, obs);
        checks++; if (obs !== '0) begin errors++; $display("FAIL crd_low_zero got %h want 0", obs); end
        access(1'b0, 3'b111, 12'h000, 20'h00000, 1'b1, 12'h123, obs);
        checks++; if (obs !== '0) begin errors++; $display("FAIL bad_sel_zero got %h want 0", obs); end
        checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL err_sel_sticky got %b want 1", err_sel); end
    endtask

    task automatic test_layer_random(input int n);
        logic [DW-1:0] obs;
        logic [DW-1:0] exp_rd;
        logic [DW-1:0] d;
        logic [11:0] wa;
        logic [11:0] ra;
        logic [2:0] sel;
        bit wr;
        bit rd;
        for (int i = 0; i < n; i++) begin
            sel = ($urandom_range(9) == 0) ? 3'($urandom) : (($urandom_range(1) == 0) ? 3'b001 : 3'b011);
            wr = $urandom_range(1); rd = ($urandom_range(3) != 0);
            wa = 12'($urandom); d = DW'($urandom);
            ra = ($urandom_range(2) == 0) ? wa : 12'($urandom);
            exp_rd = ref_read(rd, sel, ra);
            access(wr, sel, wa, d, rd, ra, obs);
            ref_write(wr, sel, wa, d);
            if ((wr || rd) && bad_sel(sel)) m_err = 1'b1;
            checks++; if (obs !== exp_rd) begin errors++; $display("FAIL rand_rd sel %b addr %h got %h want %h", sel, ra, obs, exp_rd); end
            checks++; if (err_sel !== m_err) begin errors++; $display("FAIL rand_err_sel got %b want %b", err_sel, m_err); end
        end
    endtask

    task automatic test_run_exit();
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL run_dump_valid got %b want 0", dump_valid); end
        busy = 1'b0;
        tick();
        checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL dump_entry_valid got %b want 1", dump_valid); end
        checks++; if (dump_addr !== '0) begin errors++; $display("FAIL dump_entry_addr got %0d want 0", dump_addr); end
    endtask

    task automatic test_dump(input int stop_at);
        int ea = 0;
        int k = 0;
        while (ea < int'(L1_N) && ea != stop_at && k < 8000) begin
            dump_ready = (k < 4) ? ((k == 1 || k == 2) ? 1'b0 : 1'b1) : ($urandom_range(3) != 0);
            #1;
            checks++; if (dump_valid !== 1'b1) begin errors++; $display("FAIL dump_valid idx %0d got %b want 1", ea, dump_valid); end
            checks++; if (dump_addr !== L1_AW'(ea)) begin errors++; $display("FAIL dump_addr got %0d want %0d", dump_addr, ea); end
            checks++; if (dump_data !== m_l1[ea]) begin errors++; $display("FAIL dump_data idx %0d got %h want %h", ea, dump_data, m_l1[ea]); end
            if (ea == int'(L1_N) - 1 && dump_ready) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got %b want 0", done); end
            end
            tick();
            if (dump_ready) ea++;
            k++;
        end
        dump_ready = 1'b0;
        if (k >= 8000) begin checks++; errors++; $display("FAIL dump_timeout got %0d accepts want %0d", ea, L1_N); end
    endtask

    task automatic test_done();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done got %b want 1", done); end
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL done_dump_valid got %b want 0", dump_valid); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL done_load_ready got %b want 0", load_ready); end
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = 20'h0F0F0; busy = $urandom_range(1); dump_ready = 1'b1;
            tick();
            checks++; if (done !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL done_hold got done %b ready %b want 1 0", done, ready); end
        end
        load_valid = 1'b0; busy = 1'b0; dump_ready = 1'b0;
        iaddr = 12'd0;
        #1;
        checks++; if (idata !== m_img[0]) begin errors++; $display("FAIL done_img_untouched got %h want %h", idata, m_img[0]); end
    endtask

    task automatic test_reset_mid_dump();
        logic [DW-1:0] obs;
        checks++; if (dump_addr !== L1_AW'(500)) begin errors++; $display("FAIL mid_dump_addr got %0d want 500", dump_addr); end
        access(1'b0, 3'b000, 12'h000, 20'h00000, 1'b1, 12'h001, obs);
        checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL mid_err_sel got %b want 1", err_sel); end
        test_reset();
        checks++; if (dump_addr !== '0 || ready !== 1'b0) begin errors++; $display("FAIL mid_reset_clear got addr %0d ready %b want 0 0", dump_addr, ready); end
    endtask

    initial begin
        test_reset();
        test_load(IMG_N, 1'b1);
        test_idata(12);
        test_arm();
        test_idata(6);
        test_fill();
        test_layer_directed();
        test_layer_random(400);
        test_run_exit();
        test_dump(-1);
        test_done();
        test_reset();
        test_load(100, 1'b0);
        test_reset();
        test_load(IMG_N, 1'b1);
        test_idata(20);
        test_arm();
        test_run_exit();
        test_dump(500);
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_mem_responder.md
# conv_mem_responder

Memory-side responder for the convolution engine's image and layer-memory ports. It holds the 4096-word input image, the layer-0 (conv/ReLU) bank and the layer-1 (max-pool) bank. It serves the engine's `iaddr`/`idata`, `cwr`/`crd`/`csel` accesses, and handles the handshake around `ready`/`busy`. A host loads the image through a valid/ready stream and drains the layer-1 result through a second valid/ready stream.

## Interface
Parameters:
- `DW`, 20: data word width (signed fixed point, 4.16 format).
- `IMG_AW`, 12: image and L0 address width (4096 words).
- `L1_AW`, 10: L1 address width (1024 words).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load_valid` in 1: host image word valid.
- `load_data` in DW: image word, raster order starting at address 0.
- `load_ready` out 1: high only in LOAD.
- `ready` out 1: start request to the engine.
- `busy` in 1: engine busy flag.
- `iaddr` in IMG_AW: image read address.
- `idata` out DW: combinational read `img[iaddr]`.
- `cwr` in 1: layer write strobe.
- `caddr_wr` in 12: layer write address.
- `cdata_wr` in DW: layer write data.
- `crd` in 1: layer read strobe.
- `caddr_rd` in 12: layer read address.
- `cdata_rd` out DW: layer read data, combinational.
- `csel` in 3: bank select.
- `dump_valid` out 1: L1 result word valid.
- `dump_data` out DW: L1 word at `dump_addr`.
- `dump_addr` out L1_AW: index of the current dump word.
- `done` out 1: all 1024 L1 words accepted by the host.
- `err_sel` out 1: sticky flag; an access used an invalid `csel`.

## Operation
- FSM states: LOAD, ARM, RUN, DUMP, DONE. Reset enters LOAD.
- LOAD:
  - `load_ready`=1.
  - On `load_valid`, `img[ld_cnt]<=load_data` and `ld_cnt` increments.
  - After the word at address 4095 is accepted, go to ARM.
- ARM:
  - `ready`=1.
  - When `busy`=1 is sampled, go to RUN and drop `ready` on the same edge.
- RUN:
  - Layer accesses are serviced.
  - When `busy`=0 is sampled, go to DUMP with `dump_addr`=0.
- Layer accesses are serviced in every state; they are not gated by the FSM.
- Bank decode:
  - `csel`=3'b001 selects L0, full 12-bit address.
  - `csel`=3'b011 selects L1, address bits [9:0]. Bits [11:10] are ignored.
  - Any other `csel` value is invalid.
- Writes: on an edge with `cwr`=1, the selected bank is written. An invalid `csel` drops the write and sets `err_sel`.
- Reads:
  - `cdata_rd` = selected bank at `caddr_rd` when `crd`=1.
  - `cdata_rd` = 0 when `crd`=0 or `csel` is invalid.
  - `crd`=1 with an invalid `csel` sets `err_sel`.
- If `cwr` and `crd` hit the same bank and address in the same cycle, `cdata_rd` returns the pre-write value; the new value is visible from the next cycle.
- DUMP:
  - `dump_valid`=1 and `dump_data`=`L1[dump_addr]`.
  - On `dump_valid&dump_ready`, `dump_addr` increments.
  - Acceptance at 1023 moves to DONE.
  - Under backpressure, `dump_data` and `dump_addr` are held stable.
- DONE: `done`=1 and all host handshakes are low. The block stays in DONE until `reset`.
- `load_valid` outside LOAD is ignored and does not write `img`.

## Timing
- Reset values (synchronous): `load_ready`=1, `ready`=0, `dump_valid`=0, `dump_addr`=0, `done`=0, `err_sel`=0, `ld_cnt`=0.
- Memory arrays are not cleared by reset.
- `idata` and `cdata_rd` are zero-latency, combinational from registered addresses. The engine registers the address in cycle N and consumes the data in cycle N+1.
- Write latency is 1: data is visible to reads in the cycle after the `cwr` edge.
- `ready` goes high in the cycle after the 4096th load acceptance. It stays high until the first cycle in which `busy`=1 is sampled.
- RUN exits in the cycle after `busy` is sampled low. `dump_valid` rises on that same edge.
- DUMP throughput: 1 word per cycle with `dump_ready` held high. 1024 cycles from DUMP entry to `done`.
- Reset mid-operation (any state):
  - Next state is LOAD, counters and flags clear, `ready` drops.
  - A partially loaded image must be reloaded from address 0.

## Test plan
- Load ramp `img[a]=a`; drive `iaddr`=0, 64, 4095 -> `idata`=0x00000, 0x00040, 0x00FFF in the same cycle. `ready` rises one cycle after word 4095.
- In ARM, hold `busy`=0 for 10 cycles, then 1 -> `ready` stays 1 for those cycles, then drops on the edge that samples `busy`=1.
- `cwr`, `csel`=001, `caddr_wr`=0x123, `cdata_wr`=0x0ABCD. Next cycle `crd`, `csel`=001, `caddr_rd`=0x123 -> `cdata_rd`=0x0ABCD. Same-cycle write/read to the same address -> old value.
- `csel`=011 write at addr 0x7FF (L1 index 0x3FF) with data 0x12345; `csel`=010 write -> dropped and `err_sel`=1. Read back L1[0x3FF]=0x12345.
- Drop `busy`; pull dump with `dump_ready` toggling 1,0,0,1 -> `dump_addr` and `dump_data` held while not ready. `done` asserts after the 1024th accept; L1 contents match the written pattern.
- Assert `reset` in DUMP at `dump_addr`=500 -> next cycle LOAD, `load_ready`=1, `done`=0, `dump_valid`=0, `err_sel`=0.
